// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: bus widths, ld_op codes,
// response-wait state encodings and the packed layouts of both buses.
package mem_stage_pkg;

   localparam int ES_TO_MS_BUS_WD     = 74;
   localparam int MS_TO_WS_BUS_WD     = 70;
   localparam int MS_TO_DS_FWD_BUS_WD = 39;

   localparam logic [2:0] LD_NONE = 3'b000;
   localparam logic [2:0] LD_B    = 3'b001;
   localparam logic [2:0] LD_H    = 3'b010;
   localparam logic [2:0] LD_W    = 3'b011;
   localparam logic [2:0] LD_BU   = 3'b100;
   localparam logic [2:0] LD_HU   = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } ms_state_t;

   typedef struct packed {
      logic [2:0]  ld_op;
      logic        req_issued;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] pc;
   } es_to_ms_t;

   typedef struct packed {
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic [31:0] pc;
   } ms_to_ws_t;

   function automatic logic is_load(input logic [2:0] op);
      return (op >= LD_B) && (op <= LD_HU);
   endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// load_extend: picks the addressed byte/half of a load word and extends it.
// Ports: ld_op (load kind), addr (low address bits), rdata (raw word) -> result.
module load_extend
   import mem_stage_pkg::*;
(
   input  logic [2:0]  ld_op,
   input  logic [1:0]  addr,
   input  logic [31:0] rdata,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{addr, 3'b000} +: 8];
      // Halves are always aligned; the low address bit is ignored.
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      result = rdata;
      case (ld_op)
         LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
         LD_H:    result = {{16{half_sel[15]}}, half_sel};
         LD_W:    result = rdata;
         LD_BU:   result = {24'd0, byte_sel};
         LD_HU:   result = {16'd0, half_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: fourth pipeline stage; waits for data-SRAM responses, extends
// load data and keeps it in a local buffer while write-back stalls.
// Ports: clk/reset (sync, active-high); es_to_ms_valid/bus, ms_allowin (from es);
// ms_to_ws_valid/bus, ws_allowin (to ws); ms_to_ds_valid (to decode);
// data_sram_data_ok/rdata (SRAM response).
// Optional: MEM_STAGE_FWD_EN adds ms_to_ds_fwd_bus = {fwd_valid, fwd_blocked,
// dest, final_result} for decode forwarding.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic                       ms_to_ds_valid,
   input  logic                       data_sram_data_ok,
   input  logic [31:0]                data_sram_rdata
`ifdef MEM_STAGE_FWD_EN
   ,
   output logic [MS_TO_DS_FWD_BUS_WD-1:0] ms_to_ds_fwd_bus
`endif
);

   es_to_ms_t ms_bus_r;
   ms_state_t state;
   ms_state_t state_nxt;
   logic      ms_valid;
   logic      ms_ready_go;
   logic      capture;
   logic      buf_load;
   logic [31:0] data_buf;
   logic [31:0] load_data;
   logic [31:0] ext_data;
   logic [31:0] final_result;
   es_to_ms_t   es_bus;

   assign es_bus = es_to_ms_t'(es_to_ms_bus);

   assign ms_ready_go = (state == WAIT) ? data_sram_data_ok : 1'b1;
   assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
   assign capture     = es_to_ms_valid & ms_allowin;
   assign buf_load    = (state == WAIT) & data_sram_data_ok & ~ws_allowin;

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT: begin
            if (data_sram_data_ok)
               state_nxt = ws_allowin ? IDLE : HOLD;
         end
         HOLD: begin
            if (ws_allowin)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // A capture only happens once the held instruction is leaving.
      if (capture)
         state_nxt = es_bus.req_issued ? WAIT : IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid <= 1'b0;
         state    <= IDLE;
         data_buf <= 32'd0;
      end else begin
         state <= state_nxt;
         if (ms_allowin)
            ms_valid <= es_to_ms_valid;
         if (buf_load)
            data_buf <= data_sram_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (capture)
         ms_bus_r <= es_bus;
   end

   assign load_data = (state == HOLD) ? data_buf : data_sram_rdata;

   load_extend u_load_extend (
      .ld_op  (ms_bus_r.ld_op),
      .addr   (ms_bus_r.alu_result[1:0]),
      .rdata  (load_data),
      .result (ext_data)
   );

   assign final_result = is_load(ms_bus_r.ld_op) ? ext_data
                                                  : ms_bus_r.alu_result;

   assign ms_to_ws_valid = ms_valid & ms_ready_go;
   assign ms_to_ds_valid = ms_valid;
   assign ms_to_ws_bus   = {ms_bus_r.gr_we, ms_bus_r.dest,
                            final_result, ms_bus_r.pc};

`ifdef MEM_STAGE_FWD_EN
   logic fwd_valid;
   logic fwd_blocked;
   assign fwd_valid   = ms_valid & ms_bus_r.gr_we & (ms_bus_r.dest != 5'd0);
   assign fwd_blocked = (state == WAIT) & ~data_sram_data_ok;
   assign ms_to_ds_fwd_bus = {fwd_valid, fwd_blocked, ms_bus_r.dest,
                              final_result};
`endif

endmodule
